// File: rtl/ysyx_25020037_ifu_pkg.sv
// Shared widths, reset vector and FSM encoding for the instruction fetch unit.
package ysyx_25020037_ifu_pkg;

    localparam int          XLEN             = 32;
    localparam int          FU_TO_DU_BUS_WD  = 64;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h3000_0000;
    localparam logic [31:0] INST_BYTES       = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_HOLD = 2'd3
    } ifu_state_e;

    // Sequential successor; wraps naturally at 2^32.
    function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
        return pc + INST_BYTES;
    endfunction

endpackage

// File: rtl/ysyx_25020037_ifu_if.sv
// Fetch-side signal bundle: decode handshake, execute redirect and the AR/R read channel.
interface ysyx_25020037_ifu_if;
    import ysyx_25020037_ifu_pkg::*;

    logic                       idu_ready;
    logic                       ifu_valid;
    logic [FU_TO_DU_BUS_WD-1:0] fu_to_du_bus;
    logic                       ifu_err;

    logic                       exu_dnpc_valid;
    logic [XLEN-1:0]            exu_dnpc;

    logic                       arvalid;
    logic                       arready;
    logic [XLEN-1:0]            araddr;
    logic                       rvalid;
    logic                       rready;
    logic [XLEN-1:0]            rdata;
    logic [1:0]                 rresp;

    modport master (
        input  idu_ready,
        output ifu_valid,
        output fu_to_du_bus,
        output ifu_err,
        input  exu_dnpc_valid,
        input  exu_dnpc,
        output arvalid,
        input  arready,
        output araddr,
        input  rvalid,
        output rready,
        input  rdata,
        input  rresp
    );

    modport slave (
        output idu_ready,
        input  ifu_valid,
        input  fu_to_du_bus,
        input  ifu_err,
        output exu_dnpc_valid,
        output exu_dnpc,
        input  arvalid,
        output arready,
        input  araddr,
        output rvalid,
        input  rready,
        output rdata,
        output rresp
    );

endinterface

// File: rtl/ysyx_25020037_ifu.sv
// Instruction fetch: owns the PC, issues one read at a time and hands {pc, inst} to decode.
// Redirects overwrite the PC immediately; an in-flight wrong-path beat is dropped via discard_q.
import ysyx_25020037_ifu_pkg::*;

module ysyx_25020037_ifu #(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    ysyx_25020037_ifu_if.master   ifu
);

    ifu_state_e                 state_q, state_d;
    logic [XLEN-1:0]            pc_q, pc_d;
    logic                       valid_q, valid_d;
    logic [FU_TO_DU_BUS_WD-1:0] bus_q, bus_d;
    logic                       err_q, err_d;
    logic                       arvalid_q, arvalid_d;
    logic                       rready_q, rready_d;
    logic                       discard_q, discard_d;

    logic                       redirect;

    assign redirect = ifu.exu_dnpc_valid;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        valid_d   = valid_q;
        bus_d     = bus_q;
        err_d     = err_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        discard_d = discard_q;

        case (state_q)
            S_IDLE: begin
                state_d   = S_AR;
                arvalid_d = 1'b1;
            end
            S_AR: begin
                if (ifu.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_R;
                    // Address already accepted with the old PC: its beat must be dropped.
                    if (redirect) discard_d = 1'b1;
                end
            end
            S_R: begin
                if (ifu.rvalid) begin
                    rready_d = 1'b0;
                    if (discard_q || redirect) begin
                        discard_d = 1'b0;
                        arvalid_d = 1'b1;
                        state_d   = S_AR;
                    end else begin
                        valid_d = 1'b1;
                        bus_d   = {pc_q, ifu.rdata};
                        err_d   = (ifu.rresp != 2'b00);
                        state_d = S_HOLD;
                    end
                end else if (redirect) begin
                    discard_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect || ifu.idu_ready) begin
                    valid_d   = 1'b0;
                    arvalid_d = 1'b1;
                    state_d   = S_AR;
                    pc_d      = next_seq_pc(pc_q);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Redirect wins over the sequential increment in every state.
        if (redirect) pc_d = ifu.exu_dnpc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            valid_q   <= 1'b0;
            bus_q     <= '0;
            err_q     <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            valid_q   <= valid_d;
            bus_q     <= bus_d;
            err_q     <= err_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            discard_q <= discard_d;
        end
    end

    assign ifu.ifu_valid    = valid_q;
    assign ifu.fu_to_du_bus = bus_q;
    assign ifu.ifu_err      = err_q;
    assign ifu.arvalid      = arvalid_q;
    assign ifu.araddr       = pc_q;
    assign ifu.rready       = rready_q;

endmodule

// File: tb/tb_ysyx_25020037_ifu.sv
// Self-checking bench for ysyx_25020037_ifu: behavioural memory responder plus
// address/word scoreboards filled by the stimulus and drained by a negedge monitor.
module tb_ysyx_25020037_ifu;

    localparam logic [31:0] RST_PC = 32'h3000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ysyx_25020037_ifu_if ifc ();

    ysyx_25020037_ifu #(.RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .ifu (ifc.master)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] exp_addr_q[$];
    logic [64:0] exp_word_q[$];

    logic        mem_pat   = 1'b0;
    logic        mem_err   = 1'b0;
    logic        mem_stall = 1'b0;
    logic        mem_flush = 1'b0;
    int          mem_lat   = 0;

    logic        ar_fire   = 1'b0;
    logic        r_fire    = 1'b0;
    logic [31:0] ar_addr_s = '0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic pat);
        return pat ? (a ^ 32'h5A5A_0013) : 32'h0000_0013;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Observe what the DUT will see at the coming posedge.
    always @(negedge clk) begin
        ar_fire   = ifc.arvalid && ifc.arready;
        ar_addr_s = ifc.araddr;
        r_fire    = ifc.rvalid && ifc.rready;
        if (ar_fire && exp_addr_q.size() > 0)
            check("araddr", ifc.araddr, exp_addr_q.pop_front());
        if (ifc.ifu_valid && ifc.idu_ready && !ifc.exu_dnpc_valid) begin
            if (exp_word_q.size() == 0)
                check("word_expected", exp_word_q.size(), 1);
            else
                check("word", {ifc.ifu_err, ifc.fu_to_du_bus}, exp_word_q.pop_front());
        end
    end

    // Single-outstanding memory: rvalid mem_lat cycles after the address beat.
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          cnt = 0;
    always @(posedge clk) begin
        #1;
        if (mem_flush) begin
            pend       = 1'b0;
            ifc.rvalid = 1'b0;
        end else begin
            if (r_fire) begin
                ifc.rvalid = 1'b0;
                pend       = 1'b0;
            end
            if (ar_fire) begin
                pend      = 1'b1;
                pend_addr = ar_addr_s;
                cnt       = mem_lat;
            end
            if (pend && !ifc.rvalid) begin
                if (cnt == 0) begin
                    if (!mem_stall) begin
                        ifc.rvalid = 1'b1;
                        ifc.rdata  = mem_word(pend_addr, mem_pat);
                        ifc.rresp  = mem_err ? 2'b10 : 2'b00;
                    end
                end else begin
                    cnt--;
                end
            end
        end
    end

    task automatic push_word(input logic [31:0] pc, input logic err);
        exp_word_q.push_back({err, pc, mem_word(pc, mem_pat)});
    endtask

    task automatic drain_words();
        int n = 0;
        ifc.idu_ready = 1'b1;
        while (exp_word_q.size() != 0 && n < 200) begin
            step(1);
            n++;
        end
        ifc.idu_ready = 1'b0;
        check("tmo_drain", 32'(n >= 200), 0);
    endtask

    task automatic accept_one(input logic [31:0] pc, input logic err);
        push_word(pc, err);
        drain_words();
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!ifc.ifu_valid && n < 200) begin
            step(1);
            n++;
        end
        check("tmo_valid", 32'(n >= 200), 0);
    endtask

    task automatic wait_rready();
        int n = 0;
        while (!ifc.rready && n < 200) begin
            step(1);
            n++;
        end
        check("tmo_rready", 32'(n >= 200), 0);
    endtask

    task automatic redirect(input logic [31:0] target, input logic rdy);
        ifc.exu_dnpc_valid = 1'b1;
        ifc.exu_dnpc       = target;
        ifc.idu_ready      = rdy;
        step(1);
        ifc.exu_dnpc_valid = 1'b0;
        ifc.idu_ready      = 1'b0;
    endtask

    initial begin
        ifc.idu_ready      = 1'b0;
        ifc.exu_dnpc_valid = 1'b0;
        ifc.exu_dnpc       = '0;
        ifc.arready        = 1'b1;
        ifc.rvalid         = 1'b0;
        ifc.rdata          = '0;
        ifc.rresp          = 2'b00;

        step(2);
        check("rst_valid",   ifc.ifu_valid, 0);
        check("rst_bus",     ifc.fu_to_du_bus, 0);
        check("rst_err",     ifc.ifu_err, 0);
        check("rst_arvalid", ifc.arvalid, 0);
        check("rst_rready",  ifc.rready, 0);
        check("rst_araddr",  ifc.araddr, RST_PC);

        // Free-running fetch from reset.
        exp_addr_q.push_back(32'h3000_0000);
        exp_addr_q.push_back(32'h3000_0004);
        exp_addr_q.push_back(32'h3000_0008);
        push_word(32'h3000_0000, 1'b0);
        push_word(32'h3000_0004, 1'b0);
        push_word(32'h3000_0008, 1'b0);
        rst = 1'b0;
        check("pre_ar", ifc.arvalid, 0);
        step(1);
        check("first_ar", ifc.arvalid, 1);
        drain_words();
        check("seq_addr_left", exp_addr_q.size(), 0);

        // Backpressure in S_HOLD.
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid",   ifc.ifu_valid, 1);
            check("bp_bus",     ifc.fu_to_du_bus, {32'h3000_000C, 32'h0000_0013});
            check("bp_arvalid", ifc.arvalid, 0);
            step(1);
        end
        exp_addr_q.push_back(32'h3000_0010);
        accept_one(32'h3000_000C, 1'b0);
        mem_pat = 1'b1;
        wait_valid();
        check("bp_addr_left", exp_addr_q.size(), 0);

        // Redirect in S_HOLD together with idu_ready.
        exp_addr_q.push_back(32'h4000_0100);
        redirect(32'h4000_0100, 1'b1);
        check("hold_rd_valid",   ifc.ifu_valid, 0);
        check("hold_rd_arvalid", ifc.arvalid, 1);
        check("hold_rd_araddr",  ifc.araddr, 32'h4000_0100);
        wait_valid();
        check("hold_rd_bus", ifc.fu_to_du_bus, {32'h4000_0100, mem_word(32'h4000_0100, 1'b1)});

        // Redirect while waiting for the R beat.
        mem_lat = 3;
        exp_addr_q.push_back(32'h4000_0104);
        accept_one(32'h4000_0100, 1'b0);
        wait_rready();
        exp_addr_q.push_back(32'h8000_0040);
        redirect(32'h8000_0040, 1'b0);
        accept_one(32'h8000_0040, 1'b0);
        check("r_rd_addr_left", exp_addr_q.size(), 0);
        wait_valid();
        mem_lat = 0;
        check("after_rd_bus", ifc.fu_to_du_bus, {32'h8000_0044, mem_word(32'h8000_0044, 1'b1)});

        // Error response.
        mem_err = 1'b1;
        exp_addr_q.push_back(32'h8000_0048);
        accept_one(32'h8000_0044, 1'b0);
        wait_valid();
        check("err_flag", ifc.ifu_err, 1);
        check("err_bus",  ifc.fu_to_du_bus, {32'h8000_0048, mem_word(32'h8000_0048, 1'b1)});
        mem_err = 1'b0;
        exp_addr_q.push_back(32'h8000_004C);
        accept_one(32'h8000_0048, 1'b1);
        wait_valid();
        check("err_clear", ifc.ifu_err, 0);

        // PC wrap at the top of the address space.
        exp_addr_q.push_back(32'hFFFF_FFFC);
        exp_addr_q.push_back(32'h0000_0000);
        redirect(32'hFFFF_FFFC, 1'b0);
        wait_valid();
        accept_one(32'hFFFF_FFFC, 1'b0);
        wait_valid();
        check("wrap_bus", ifc.fu_to_du_bus, {32'h0000_0000, mem_word(32'h0000_0000, 1'b1)});
        check("wrap_addr_left", exp_addr_q.size(), 0);

        // Async reset in S_R, then a stale beat arrives.
        mem_stall = 1'b1;
        accept_one(32'h0000_0000, 1'b0);
        wait_rready();
        #2 rst = 1'b1;
        #1;
        check("arst_valid",   ifc.ifu_valid, 0);
        check("arst_bus",     ifc.fu_to_du_bus, 0);
        check("arst_err",     ifc.ifu_err, 0);
        check("arst_arvalid", ifc.arvalid, 0);
        check("arst_rready",  ifc.rready, 0);
        check("arst_araddr",  ifc.araddr, RST_PC);
        step(2);
        ifc.arready = 1'b0;
        rst = 1'b0;
        step(1);
        check("arst_ar",     ifc.arvalid, 1);
        check("arst_ar_pc",  ifc.araddr, RST_PC);
        mem_stall = 1'b0;
        step(3);
        check("late_valid",  ifc.ifu_valid, 0);
        check("late_rready", ifc.rready, 0);
        mem_flush = 1'b1;
        step(1);
        mem_flush = 1'b0;
        exp_addr_q.push_back(RST_PC);
        ifc.arready = 1'b1;
        accept_one(RST_PC, 1'b0);
        check("end_addr_left", exp_addr_q.size(), 0);
        check("end_word_left", exp_word_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
